// File: rtl/cnt_cmd_pkg.sv
// cnt_cmd_pkg: shared command/state encodings and default widths for the counter command sequencer
package cnt_cmd_pkg;
  localparam int CNT_WIDTH = 16;
  localparam int CNT_LEN_W = 16;
  typedef enum logic [1:0] {OP_NOP, OP_LOAD, OP_UP, OP_DOWN} cmd_op_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;
endpackage

// File: rtl/cnt_cmd_steps.sv
// cnt_cmd_steps: step down-counter holding the remaining RUN cycles of an UP/DOWN command
module cnt_cmd_steps
  import cnt_cmd_pkg::*;
#(
  parameter int LEN_W = CNT_LEN_W
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             last_o
);
  logic [LEN_W-1:0] remaining_q, remaining_d;
  // saturate at zero so a stray decrement never wraps to the maximum length
  always_comb remaining_d = load_i ? len_i
                          : (dec_i && remaining_q != '0) ? remaining_q - LEN_W'(1)
                          : remaining_q;
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) remaining_q <= '0;
    else       remaining_q <= remaining_d;
  assign last_o = remaining_q == LEN_W'(1);
endmodule

// File: rtl/cnt_cmd_seq.sv
// cnt_cmd_seq: turns LOAD/UP/DOWN/NOP commands into cycle-exact controls for the 16-bit up/down counter
module cnt_cmd_seq
  import cnt_cmd_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH,
  parameter int LEN_W = CNT_LEN_W
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic [WIDTH-1:0] data_in,
  output logic             ld_cnt,
  output logic             updn_cnt,
  output logic             count_enb,
  output logic             busy,
  output logic             done,
  output logic             aborted
);
  state_e           state_q;
  logic [WIDTH-1:0] data_in_q;
  logic             ld_cnt_q, updn_q, count_enb_q, busy_q, done_q, aborted_q;
  logic [LEN_W-1:0] len;
  logic             start_run, last;
  assign len       = cmd_data[LEN_W-1:0];
  assign cmd_ready = state_q == S_IDLE;
  assign start_run = cmd_valid & cmd_ready & cmd_op[1] & (len != '0);
  cnt_cmd_steps #(.LEN_W(LEN_W)) u_steps (
    .clk    (clk),
    .rst_   (rst_),
    .load_i (start_run),
    .dec_i  (state_q == S_RUN),
    .len_i  (len),
    .last_o (last)
  );
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) begin
      state_q     <= S_IDLE;
      data_in_q   <= '0;
      ld_cnt_q    <= 1'b0;
      updn_q      <= 1'b0;
      count_enb_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      ld_cnt_q    <= 1'b0;
      count_enb_q <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      case (state_q)
        S_IDLE: if (cmd_valid) begin
          busy_q <= 1'b1;
          if (cmd_op_e'(cmd_op) == OP_LOAD) begin
            state_q   <= S_LOAD;
            ld_cnt_q  <= 1'b1;
            data_in_q <= cmd_data;
          end else if (start_run) begin
            state_q     <= S_RUN;
            count_enb_q <= 1'b1;
            updn_q      <= cmd_op_e'(cmd_op) == OP_UP;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        // the final step wins over a simultaneous abort: that step has already been counted
        S_RUN: if (last || abort) begin
          state_q   <= S_DONE;
          done_q    <= 1'b1;
          aborted_q <= !last;
        end else count_enb_q <= 1'b1;
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  assign data_in   = data_in_q;
  assign ld_cnt    = ld_cnt_q;
  assign updn_cnt  = updn_q;
  assign count_enb = count_enb_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
endmodule

// File: tb/tb_cnt_cmd_seq.sv
// tb_cnt_cmd_seq: directed bench for cnt_cmd_seq driving a behavioural 16-bit up/down counter
module tb_cnt_cmd_seq;
  import cnt_cmd_pkg::*;
  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_data = 16'h0;
  logic        abort = 1'b0;
  logic [15:0] data_in;
  logic        ld_cnt, updn_cnt, count_enb, busy, done, aborted;
  logic [15:0] dout;
  int          checks = 0;
  int          failures = 0;
  int          ld_n, en_n, up_n, lat;
  logic        ab;

  cnt_cmd_seq dut (
    .clk       (clk),
    .rst_      (rst_),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .abort     (abort),
    .data_in   (data_in),
    .ld_cnt    (ld_cnt),
    .updn_cnt  (updn_cnt),
    .count_enb (count_enb),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  always #5 clk = ~clk;

  // the downstream counter
  always @(posedge clk)
    if (ld_cnt) dout <= data_in;
    else if (count_enb) dout <= updn_cnt ? dout + 16'd1 : dout - 16'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [15:0] d, input int ab_after);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    ld_n = 0; en_n = 0; up_n = 0; lat = -1; ab = 1'b0;
    for (int i = 1; i <= 300 && lat < 0; i++) begin
      @(negedge clk);
      if (ld_cnt) ld_n++;
      if (count_enb) begin
        en_n++;
        if (updn_cnt) up_n++;
        if (en_n == ab_after) abort = 1'b1;
      end
      if (done) begin
        lat   = i;
        ab    = aborted;
        abort = 1'b0;
      end
    end
    chk("done_seen", 32'(lat >= 0), 32'd1);
    @(negedge clk);
    chk("ready_after_done", cmd_ready, 1);
    chk("idle_busy", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ld", ld_cnt, 0);
    chk("rst_enb", count_enb, 0);
    chk("rst_done", done, 0);
    chk("rst_data_in", data_in, 0);
    rst_ = 1'b1;
    @(negedge clk);

    do_cmd(OP_LOAD, 16'h00A5, 0);
    chk("load_ld_cycles", ld_n, 1);
    chk("load_latency", lat, 2);
    chk("load_data_in", data_in, 16'h00A5);
    chk("load_dout", dout, 16'h00A5);
    chk("load_enb", en_n, 0);

    do_cmd(OP_LOAD, 16'h0010, 0);
    do_cmd(OP_UP, 16'd5, 0);
    chk("up_enb", en_n, 5);
    chk("up_dir", up_n, 5);
    chk("up_latency", lat, 6);
    chk("up_dout", dout, 16'h0015);
    chk("up_aborted", ab, 0);

    do_cmd(OP_LOAD, 16'h0002, 0);
    do_cmd(OP_DOWN, 16'd4, 0);
    chk("down_enb", en_n, 4);
    chk("down_dir", up_n, 0);
    chk("down_latency", lat, 5);
    chk("down_dout", dout, 16'hFFFE);
    chk("down_aborted", ab, 0);
    chk("down_updn_held", updn_cnt, 0);

    do_cmd(OP_UP, 16'd10, 2);
    chk("abort_enb", en_n, 2);
    chk("abort_latency", lat, 3);
    chk("abort_flag", ab, 1);
    chk("abort_dout", dout, 16'h0000);
    chk("abort_cleared", aborted, 0);

    do_cmd(OP_UP, 16'd3, 3);
    chk("abort_last_enb", en_n, 3);
    chk("abort_last_flag", ab, 0);
    chk("abort_last_dout", dout, 16'h0003);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle_ignored", busy, 0);

    do_cmd(OP_UP, 16'd0, 0);
    chk("up0_enb", en_n, 0);
    chk("up0_ld", ld_n, 0);
    chk("up0_latency", lat, 1);
    do_cmd(OP_NOP, 16'h1234, 0);
    chk("nop_enb", en_n, 0);
    chk("nop_ld", ld_n, 0);
    chk("nop_latency", lat, 1);
    chk("nop_dout", dout, 16'h0003);

    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_data  = 16'h1234;
    @(negedge clk);
    chk("hold_ld1", ld_cnt, 1);
    chk("hold_data1", data_in, 16'h1234);
    cmd_data = 16'h5678;
    @(negedge clk);
    chk("hold_done", done, 1);
    chk("hold_not_ready", cmd_ready, 0);
    chk("hold_data_kept", data_in, 16'h1234);
    @(negedge clk);
    chk("hold_ready", cmd_ready, 1);
    chk("hold_no_ld", ld_cnt, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("hold_ld2", ld_cnt, 1);
    chk("hold_data2", data_in, 16'h5678);
    repeat (2) @(negedge clk);
    chk("hold_dout", dout, 16'h5678);

    cmd_valid = 1'b1;
    cmd_op    = OP_UP;
    cmd_data  = 16'd100;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    en_n = 0;
    for (int i = 0; i < 50 && en_n < 7; i++) begin
      @(negedge clk);
      if (count_enb) en_n++;
    end
    chk("rst_mid_steps", en_n, 7);
    #2 rst_ = 1'b0;
    #1;
    chk("rst_mid_enb", count_enb, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    chk("rst_mid_done", done, 0);
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    chk("rst_rel_enb", count_enb, 0);
    chk("rst_rel_ready", cmd_ready, 1);
    do_cmd(OP_LOAD, 16'h0040, 0);
    do_cmd(OP_UP, 16'd2, 0);
    chk("post_rst_enb", en_n, 2);
    chk("post_rst_dout", dout, 16'h0042);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
